// File: rtl/shift_and_subtract_divider_if.sv
// Handshake and operand/result bundle for the shift-and-subtract divider.
interface shift_and_subtract_divider_if #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    // Requester side: issues operands, observes status and results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/shift_and_subtract_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first,
// with a start/busy/done handshake and a divide-by-zero flag.
module shift_and_subtract_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic clk,
    input  logic rst,
    shift_and_subtract_divider_if.slave bus
);
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [DIVIDEND_W-1:0] d_q, d_d;        // dividend shift register
    logic [DIVIDEND_W-1:0] q_q, q_d;        // quotient shift register
    logic [DIVISOR_W-1:0]  v_q, v_d;        // captured divisor
    // The partial remainder is always < divisor after a restore, so its
    // extra bit is only needed transiently in the trial value t.
    logic [DIVISOR_W-1:0]  r_q, r_d;
    logic [DIVISOR_W:0]    t;               // trial value, one bit wider
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  dbz_q, dbz_d;

    // Next-state, datapath step and handshake outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        state_d  = state_q;
        d_d      = d_q;
        q_d      = q_q;
        v_d      = v_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;
        t        = {r_q, d_q[DIVIDEND_W-1]};
        bus.busy = 1'b0;
        bus.done = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                bus.done = (state_q == DONE);
                state_d  = IDLE;
                if (bus.start) begin
                    d_d   = bus.dividend;
                    v_d   = bus.divisor;
                    r_d   = '0;
                    q_d   = '0;
                    cnt_d = CNT_W'(DIVIDEND_W);
                    if (bus.divisor == '0) begin
                        // Skip iteration entirely; present the saturated result.
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                // NOTE: blocking assignments here let q_d/r_d be reused below in the same pass.
                if (t >= {1'b0, v_q}) begin
                    r_d = DIVISOR_W'(t - {1'b0, v_q});
                    q_d = {q_q[DIVIDEND_W-2:0], 1'b1};
                end else begin
                    r_d = t[DIVISOR_W-1:0];
                    q_d = {q_q[DIVIDEND_W-2:0], 1'b0};
                end
                d_d   = d_q << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    quot_d  = q_d;
                    rem_d   = r_d;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; synchronous reset discards any partial result.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= IDLE;
            d_q     <= '0;
            q_q     <= '0;
            v_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            q_q     <= q_d;
            v_q     <= v_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule
